// File: rtl/zx_kbd_pkg.sv
// Shared types and default constants for the PS/2 keyboard receiver.
package zx_kbd_pkg;

  localparam int unsigned FilterLenDef  = 8;
  localparam int unsigned TimeoutCycDef = 50000;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_if.sv
// PS/2 line inputs plus FIFO write port and status pulses of the receiver.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       full;
  logic [7:0] w_data;
  logic       wr;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  ps2_clk, ps2_data, full,
    output w_data, wr, busy, parity_err, frame_err, overrun
  );

  modport slave (
    output ps2_clk, ps2_data, full,
    input  w_data, wr, busy, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/ps2_filter.sv
// Synchronises and debounces the PS/2 clock; emits a one-cycle tick on each filtered falling edge.
module ps2_filter
  import zx_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FilterLenDef
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic fall_tick
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  // Count consecutive samples that disagree with the filtered level; any agreeing sample restarts.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
      fall_d = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign filt      = filt_q;
  assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity, stop; writes bytes to a FIFO.
module ps2_rx
  import zx_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = FilterLenDef,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDef
) (
  input logic       clk,
  input logic       reset,
  ps2_rx_if.master  bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      w_data_q, w_data_d;
  logic            wr_q, wr_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic [1:0]      dsync_q;
  logic            clk_filt;
  logic            fall_tick;
  logic            data;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.ps2_clk),
    .filt      (clk_filt),
    .fall_tick (fall_tick)
  );

  assign data = dsync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      w_data_q  <= '0;
      wr_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      dsync_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      w_data_q  <= w_data_d;
      wr_q      <= wr_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      dsync_q   <= {dsync_q[0], bus.ps2_data};
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    w_data_d  = w_data_q;
    wr_d      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    tmo_d     = (state_q == StIdle || fall_tick) ? '0 : tmo_q + 1'b1;
    if (fall_tick) begin
      unique case (state_q)
        StIdle: begin
          if (!data) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Priority: framing, then parity, then FIFO space.
          if (!data)                    ferr_d = 1'b1;
          else if (!(^{shift_q, par_q})) perr_d = 1'b1;
          else if (bus.full)            ovr_d  = 1'b1;
          else begin
            wr_d     = 1'b1;
            w_data_d = shift_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
    end
  end

  assign bus.w_data     = w_data_q;
  assign bus.wr         = wr_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, parity/stop/overrun discards, timeout, glitches, reset.
module tb_ps2_rx;

  localparam int unsigned Half = 20;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_multi = 0, n_busy = 0;
  logic [7:0] wlog[$];
  longint t_fall;

  always @(negedge clk) begin
    if (bus.wr) begin
      n_wr++;
      wlog.push_back(bus.w_data);
    end
    if (bus.parity_err) n_perr++;
    if (bus.frame_err)  n_ferr++;
    if (bus.overrun)    n_ovr++;
    if ((32'(bus.wr) + 32'(bus.parity_err) + 32'(bus.frame_err) + 32'(bus.overrun)) > 1) n_multi++;
    if (bus.busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (Half) @(negedge clk);
    bus.ps2_clk = 1'b0;
    t_fall = $time;
    repeat (Half) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic full_mid, input logic full_stop);
    bus.full = full_mid;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    bus.full = full_stop;
    ps2_bit(stp);
    repeat (Half) @(negedge clk);
    bus.ps2_data = 1'b1;
    bus.full     = 1'b0;
  endtask

  initial begin
    int b_wr, b_perr, b_ferr, b_ovr, b_busy, base;
    longint dt;
    logic [7:0] w0, w1;
    logic [7:0] pat;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.full     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_w_data", 32'(bus.w_data), 32'h00);
    check("rst_wr", 32'(bus.wr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_errs", 32'({bus.parity_err, bus.frame_err, bus.overrun}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame 0x1C, full high mid-frame but low at the stop bit.
    b_wr = n_wr; b_perr = n_perr; b_ferr = n_ferr; b_ovr = n_ovr;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    check("f1c_wr", 32'(n_wr - b_wr), 1);
    check("f1c_w_data", 32'(bus.w_data), 32'h1C);
    check("f1c_errs", 32'((n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr)), 0);
    check("f1c_idle", 32'(bus.busy), 0);

    // Back-to-back 0xF0 then 0x1C.
    b_wr = n_wr; base = wlog.size();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_wr", 32'(n_wr - b_wr), 2);
    w0 = (wlog.size() > base)     ? wlog[base]     : 8'hxx;
    w1 = (wlog.size() > base + 1) ? wlog[base + 1] : 8'hxx;
    check("b2b_first", 32'(w0), 32'hF0);
    check("b2b_second", 32'(w1), 32'h1C);

    // Bad parity.
    b_wr = n_wr; b_perr = n_perr;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_err", 32'(n_perr - b_perr), 1);
    check("par_wr", 32'(n_wr - b_wr), 0);
    check("par_w_data", 32'(bus.w_data), 32'h1C);

    // Bad stop bit.
    b_wr = n_wr; b_ferr = n_ferr;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_ferr", 32'(n_ferr - b_ferr), 1);
    check("stop_wr", 32'(n_wr - b_wr), 0);

    // Overrun.
    b_wr = n_wr; b_ovr = n_ovr; b_ferr = n_ferr;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ovr_pulse", 32'(n_ovr - b_ovr), 1);
    check("ovr_wr", 32'(n_wr - b_wr), 0);
    check("ovr_w_data", 32'(bus.w_data), 32'h1C);
    check("ovr_noferr", 32'(n_ferr - b_ferr), 0);

    // Timeout after 4 data bits.
    b_wr = n_wr; b_ferr = n_ferr;
    pat = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pat[i]);
    check("tmo_busy", 32'(bus.busy), 1);
    while (!bus.frame_err && ($time - t_fall) < 30000) @(negedge clk);
    dt = ($time - t_fall) / 10;
    check("tmo_seen", 32'(bus.frame_err), 1);
    check("tmo_not_early", 32'(dt >= 1000), 1);
    check("tmo_not_late", 32'(dt <= 1020), 1);
    @(negedge clk);
    check("tmo_idle", 32'(bus.busy), 0);
    check("tmo_ferr_once", 32'(n_ferr - b_ferr), 1);
    check("tmo_wr", 32'(n_wr - b_wr), 0);
    bus.ps2_data = 1'b1;
    repeat (Half) @(negedge clk);

    // 2-cycle glitches while data is low must not start a frame.
    b_busy = n_busy; b_ferr = n_ferr;
    bus.ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (Half) @(negedge clk);
    check("glitch_busy", 32'(n_busy - b_busy), 0);
    check("glitch_ferr", 32'(n_ferr - b_ferr), 0);
    bus.ps2_data = 1'b1;
    repeat (Half) @(negedge clk);

    // Reset mid-frame.
    b_wr = n_wr; b_perr = n_perr; b_ferr = n_ferr; b_ovr = n_ovr;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(pat[i]);
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_w_data", 32'(bus.w_data), 32'h00);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_wr", 32'(bus.wr), 0);
    reset = 1'b0;
    bus.ps2_data = 1'b1;
    repeat (1100) @(negedge clk);
    check("mrst_no_pulses", 32'((n_wr - b_wr) + (n_perr - b_perr) + (n_ferr - b_ferr)
                                + (n_ovr - b_ovr)), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mrst_rx_wr", 32'(n_wr - b_wr), 1);
    check("mrst_rx_data", 32'(bus.w_data), 32'h1C);

    check("exclusive_pulses", 32'(n_multi), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
